// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI mode-0 flash byte reader (wake-up, 0x03 read, optional sequential burst)
//
// Optional feature macro: SPI_FLASH_READER_BURST_EN
//   When defined, csb stays low after a read (HOLD) so that a request for the
//   next sequential address only clocks another data byte.
//
// Parameters:
//   CLK_DIV      - sck half-period in clk cycles (1..255)
//   CSB_HIGH_MIN - minimum csb-deasserted time in clk cycles (>=1)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   read request
//   req_addr    in   24-bit byte address, captured at acceptance
//   req_ready   out  request accepted when high together with req_valid
//   rdata       out  returned byte, held until the next rdata_valid
//   rdata_valid out  one-cycle strobe qualifying rdata
//   busy        out  high whenever the FSM is not in IDLE
//   spi_csb     out  flash chip select, active low
//   spi_sck     out  flash clock, idles low
//   spi_mosi    out  data to flash, MSB first
//   spi_miso    in   data from flash, sampled as sck rises
module spi_flash_reader #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned CSB_HIGH_MIN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        spi_csb,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(CSB_HIGH_MIN - 1);
    localparam logic [7:0]  CMD_READ = 8'h03;
    localparam logic [7:0]  CMD_WAKE = 8'hAB;

    typedef enum logic [2:0] {
        S_INIT_WAKE,
        S_INIT_GAP,
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_GAP
`ifdef SPI_FLASH_READER_BURST_EN
        ,
        S_HOLD
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        sck_q, sck_d;
    logic        csb_q, csb_d;
    logic        mosi_q, mosi_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] gap_q, gap_d;
    logic        arm_q, arm_d;
    logic        restart_q, restart_d;

    logic        half_end;
    logic        sck_rise;
    logic        sck_fall;
    logic        run;
    logic        bit_done;
    logic        accept;
    logic        start_hdr;
    logic [23:0] start_addr;

`ifdef SPI_FLASH_READER_BURST_EN
    assign req_ready = (state_q == S_IDLE) || (state_q == S_HOLD);
`else
    assign req_ready = (state_q == S_IDLE);
`endif

    assign accept      = req_valid && req_ready;
    assign half_end    = (div_q == DIV_LAST);
    assign sck_rise    = half_end && !sck_q;
    assign sck_fall    = half_end && sck_q;

    // The bit engine runs while a state still has bits to move. INIT_WAKE only
    // runs once csb has dropped; DATA and INIT_WAKE park at bit 8 for one
    // cycle so the strobe/csb rise lands one cycle after the last sck fall.
    assign run = (state_q == S_CMD) || (state_q == S_ADDR) ||
                 ((state_q == S_DATA) && (bit_cnt_q != 5'd8)) ||
                 ((state_q == S_INIT_WAKE) && !csb_q && (bit_cnt_q != 5'd8));
    assign bit_done = run && sck_fall;

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign spi_csb     = csb_q;
    assign spi_sck     = sck_q;
    assign spi_mosi    = mosi_q;

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        sck_d         = sck_q;
        csb_d         = csb_q;
        mosi_d        = mosi_q;
        bit_cnt_d     = bit_cnt_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        addr_d        = addr_q;
        gap_d         = gap_q;
        arm_d         = arm_q;
        restart_d     = restart_q;
        start_hdr     = 1'b0;
        start_addr    = addr_q;

        if (run) begin
            if (half_end) begin
                div_d = '0;
                sck_d = ~sck_q;
            end else begin
                div_d = div_q + 8'd1;
            end
            if (bit_done) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                tx_d      = {tx_q[30:0], 1'b0};
                mosi_d    = tx_q[30];
            end
        end

        case (state_q)
            S_INIT_WAKE: begin
                if (csb_q) begin
                    // First edge after reset release only arms; csb falls on the second.
                    if (!arm_q) begin
                        arm_d = 1'b1;
                    end else begin
                        csb_d     = 1'b0;
                        sck_d     = 1'b0;
                        div_d     = '0;
                        bit_cnt_d = '0;
                        tx_d      = {CMD_WAKE, 24'h000000};
                        mosi_d    = CMD_WAKE[7];
                    end
                end else if (bit_cnt_q == 5'd8) begin
                    csb_d   = 1'b1;
                    mosi_d  = 1'b0;
                    gap_d   = '0;
                    state_d = S_INIT_GAP;
                end
            end
            S_INIT_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    start_hdr  = 1'b1;
                    start_addr = req_addr;
                end
            end
            S_CMD: begin
                if (bit_done && (bit_cnt_q == 5'd7)) begin
                    bit_cnt_d = '0;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bit_done && (bit_cnt_q == 5'd23)) begin
                    bit_cnt_d = '0;
                    mosi_d    = 1'b0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                mosi_d = 1'b0;
                if (run && sck_rise) begin
                    rx_d = {rx_q[6:0], spi_miso};
                end
                if (bit_cnt_q == 5'd8) begin
                    rdata_d       = rx_q;
                    rdata_valid_d = 1'b1;
`ifdef SPI_FLASH_READER_BURST_EN
                    state_d = S_HOLD;
`else
                    csb_d   = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
`endif
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (restart_q) begin
                        restart_d  = 1'b0;
                        start_hdr  = 1'b1;
                        start_addr = addr_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
`ifdef SPI_FLASH_READER_BURST_EN
            S_HOLD: begin
                if (accept) begin
                    addr_d = req_addr;
                    if (req_addr == (addr_q + 24'd1)) begin
                        div_d     = '0;
                        sck_d     = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                    end else begin
                        // Non-sequential: close the window and re-issue the full header after GAP.
                        csb_d     = 1'b1;
                        gap_d     = '0;
                        restart_d = 1'b1;
                        state_d   = S_GAP;
                    end
                end
            end
`endif
            default: state_d = S_INIT_WAKE;
        endcase

        if (start_hdr) begin
            state_d   = S_CMD;
            csb_d     = 1'b0;
            sck_d     = 1'b0;
            div_d     = '0;
            bit_cnt_d = '0;
            tx_d      = {CMD_READ, start_addr};
            mosi_d    = CMD_READ[7];
            addr_d    = start_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_INIT_WAKE;
            div_q         <= '0;
            sck_q         <= 1'b0;
            csb_q         <= 1'b1;
            mosi_q        <= 1'b0;
            bit_cnt_q     <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            addr_q        <= '0;
            gap_q         <= '0;
            arm_q         <= 1'b0;
            restart_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            sck_q         <= sck_d;
            csb_q         <= csb_d;
            mosi_q        <= mosi_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            addr_q        <= addr_d;
            gap_q         <= gap_d;
            arm_q         <= arm_d;
            restart_q     <= restart_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - directed self-checking bench for spi_flash_reader with a behavioural SPI flash
module tb_spi_flash_reader;

    localparam int CLK_DIV      = 2;
    localparam int CSB_HIGH_MIN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [23:0] req_addr = 24'h0;
    logic        req_ready;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        busy;
    logic        spi_csb;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_flash_reader #(
        .CLK_DIV     (CLK_DIV),
        .CSB_HIGH_MIN(CSB_HIGH_MIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .busy       (busy),
        .spi_csb    (spi_csb),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    // Behavioural flash: byte at address k is k mod 256, address auto-increments.
    int          fl_cnt = 0;
    logic [7:0]  fl_cmd = 8'h0;
    logic [23:0] fl_addr = 24'h0;
    logic        fl_sck_prev = 1'b0;
    logic        fl_csb_prev = 1'b1;
    logic [7:0]  hdr_cmd = 8'h0;
    logic [23:0] hdr_addr = 24'h0;
    int          hdr_count = 0;
    int          win_count = 0;
    int          last_cnt = 0;
    logic [7:0]  last_cmd = 8'h0;
    int          idx = 0;
    logic [7:0]  byte_val = 8'h0;

    always @(spi_csb or spi_sck) begin
        if (spi_csb) begin
            if (!fl_csb_prev) begin
                win_count = win_count + 1;
                last_cnt  = fl_cnt;
                last_cmd  = fl_cmd;
            end
            fl_cnt   = 0;
            fl_cmd   = 8'h0;
            fl_addr  = 24'h0;
            spi_miso = 1'b0;
        end else if (spi_sck && !fl_sck_prev) begin
            if (fl_cnt < 8) fl_cmd = {fl_cmd[6:0], spi_mosi};
            else if (fl_cnt < 32) fl_addr = {fl_addr[22:0], spi_mosi};
            fl_cnt = fl_cnt + 1;
            if (fl_cnt == 32) begin
                hdr_cmd   = fl_cmd;
                hdr_addr  = fl_addr;
                hdr_count = hdr_count + 1;
            end
        end else if (!spi_sck && fl_sck_prev && (fl_cnt >= 32)) begin
            idx      = fl_cnt - 32;
            byte_val = 8'(fl_addr + 24'(idx / 8));
            spi_miso = byte_val[3'(7 - (idx % 8))];
        end
        fl_sck_prev = spi_sck;
        fl_csb_prev = spi_csb;
    end

    int cyc = 0;
    int rv_count = 0;
    int hi_run = 0;
    int last_hi_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdata_valid) rv_count <= rv_count + 1;
        if (spi_csb) begin
            hi_run <= hi_run + 1;
        end else begin
            hi_run <= 0;
            if (hi_run != 0) last_hi_run <= hi_run;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wake_check(input string tag, input int w0);
        int n;
        n = 0;
        while ((win_count == w0) && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_window"}, 32'(win_count), 32'(w0 + 1));
        chk({tag, "_sck_pulses"}, 32'(last_cnt), 32'd8);
        chk({tag, "_mosi"}, 32'(last_cmd), 32'h000000AB);
        n = 0;
        while (!req_ready && (n < 60)) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_gap_ge4"}, 32'(n >= CSB_HIGH_MIN), 32'd1);
    endtask

    task automatic send_req(input logic [23:0] a, output int acc);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        chk("req_accepted", 32'(req_ready), 32'd1);
        acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 24'($urandom);
    endtask

    task automatic wait_rv(input string tag, input int acc, input int lat, input logic [7:0] exp);
        int n;
        n = 0;
        while (!rdata_valid && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(rdata_valid), 32'd1);
        if (lat > 0) chk({tag, "_latency"}, 32'(cyc - acc), 32'(lat));
        chk({tag, "_data"}, 32'(rdata), 32'(exp));
    endtask

    initial begin
        int acc, n, w0, r0, h0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_csb", 32'(spi_csb), 32'd1);
        chk("rst_sck", 32'(spi_sck), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rvalid", 32'(rdata_valid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        repeat (2) @(negedge clk);
        w0 = win_count;
        rst_n = 1'b1;
        @(negedge clk);
        chk("csb_after_edge1", 32'(spi_csb), 32'd1);
        @(negedge clk);
        chk("csb_after_edge2", 32'(spi_csb), 32'd0);
        wake_check("wake1", w0);

`ifdef SPI_FLASH_READER_BURST_EN
        w0 = win_count;
        h0 = hdr_count;
        send_req(24'h0000FE, acc);
        wait_rv("b_fe", acc, 161, 8'hFE);
        chk("b_fe_hdr_addr", 32'(hdr_addr), 32'h000000FE);
        chk("b_fe_csb_low", 32'(spi_csb), 32'd0);
        send_req(24'h0000FF, acc);
        wait_rv("b_ff", acc, 33, 8'hFF);
        send_req(24'h000100, acc);
        wait_rv("b_100", acc, 33, 8'h00);
        chk("b_one_window", 32'(win_count), 32'(w0));
        chk("b_one_header", 32'(hdr_count), 32'(h0 + 1));

        send_req(24'h000020, acc);
        wait_rv("b_20", acc, 0, 8'h20);
        send_req(24'h000500, acc);
        wait_rv("b_500", acc, 0, 8'h00);
        chk("b_500_csb_gap", 32'(last_hi_run >= CSB_HIGH_MIN), 32'd1);
        chk("b_500_cmd", 32'(hdr_cmd), 32'h00000003);
        chk("b_500_addr", 32'(hdr_addr), 32'h00000500);

        send_req(24'hFFFFFF, acc);
        wait_rv("b_fff", acc, 0, 8'hFF);
        chk("b_fff_addr", 32'(hdr_addr), 32'h00FFFFFF);
        h0 = hdr_count;
        send_req(24'h000000, acc);
        wait_rv("b_wrap", acc, 33, 8'h00);
        chk("b_wrap_no_header", 32'(hdr_count), 32'(h0));
`else
        send_req(24'h000010, acc);
        wait_rv("rd10", acc, 161, 8'h10);
        chk("rd10_csb_high", 32'(spi_csb), 32'd1);
        chk("rd10_cmd", 32'(hdr_cmd), 32'h00000003);
        chk("rd10_addr", 32'(hdr_addr), 32'h00000010);
        @(negedge clk);
        chk("rd10_pulse_width", 32'(rdata_valid), 32'd0);
        chk("rd10_rdata_hold", 32'(rdata), 32'h00000010);
        chk("rd10_busy_gap", 32'(busy), 32'd1);

        r0 = rv_count;
        w0 = win_count;
        req_valid = 1'b1;
        req_addr  = 24'h000077;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("ignored_csb", 32'(spi_csb), 32'd1);
        chk("ignored_idle", 32'(busy), 32'd0);
        chk("ignored_no_rv", 32'(rv_count), 32'(r0));
        chk("ignored_no_window", 32'(win_count), 32'(w0));

        send_req(24'hFFFFFF, acc);
        wait_rv("rdff", acc, 161, 8'hFF);
        chk("rdff_addr", 32'(hdr_addr), 32'h00FFFFFF);
        chk("rdff_csb_high", 32'(spi_csb), 32'd1);
`endif

        send_req(24'h123456, acc);
        n = 0;
        while (!((fl_cnt >= 14) && (fl_cnt < 30)) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
        chk("abort_in_addr", 32'((fl_cnt >= 14) && (fl_cnt < 30)), 32'd1);
        r0 = rv_count;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_csb", 32'(spi_csb), 32'd1);
        chk("abort_sck", 32'(spi_sck), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_rdata", 32'(rdata), 32'd0);
        repeat (3) @(negedge clk);
        w0 = win_count;
        rst_n = 1'b1;
        wake_check("wake2", w0);
        chk("abort_no_rv", 32'(rv_count), 32'(r0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
